mtr_duty_ramp: RTL and testbench
================================

// Module: mtr_duty_ramp
//
// PURPOSE
//   Upstream stage of the 11-bit PWM generators: turns signed left/right
//   speed commands into the two 11-bit duty words (0x400 = stopped).
//   Applies a per-period slew limit so wheel speed ramps rather than steps.
//   Clips the result to a safe duty window.
//   Duties change at most once per PWM period, aligned with the PWM counter
//   wrap, so that each PWM period sees a single, stable duty value.
//
// PARAMETERS
//   RAMP_STEP      8        max |change| of internal speed per update (1..255)
//   UPDATE_PERIOD  2048     clocks between updates; 2048 = one PWM11 period
//   DUTY_MIN       11'h010  lower duty clamp
//   DUTY_MAX       11'h7F0  upper duty clamp
//
// PORTS
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   en         in   1   motor enable; 0 => targets forced to 0 (ramp to stop)
//   lft_spd    in   12  signed left speed command (2's complement)
//   rght_spd   in   12  signed right speed command
//   lft_duty   out  11  duty word to left PWM11
//   rght_duty  out  11  duty word to right PWM11
//   upd        out  1   1-cycle strobe: update cycle (inputs sampled here)
//   at_target  out  1   both internal speeds equal their clipped targets
//
// BEHAVIOUR
//   Clock, reset and timing
//   - Reset is asynchronous and active-low on rst_n; clock is clk.
//   - Reset values: period cnt=0, cur_l=cur_r=0, lft_duty=rght_duty=11'h400,
//     upd=0, at_target=1. Reset mid-ramp takes effect immediately.
//   - Period counter: free-running, width $clog2(UPDATE_PERIOD).
//     Wraps from UPDATE_PERIOD-1 to 0.
//   - upd=1 exactly in cycles where cnt==UPDATE_PERIOD-1.
//     The first upd after reset release occurs UPDATE_PERIOD cycles later.
//   - Inputs (en, lft_spd, rght_spd) are sampled only in the upd cycle.
//     Changes between updates are ignored.
//   Per channel, at the edge ending an upd cycle
//   - tgt = en ? sat(spd, -1023..+1023) : 0.
//     The 12-bit input range -2048..2047 is saturated, never wrapped.
//   - diff = tgt - cur, computed 13-bit signed.
//   - |diff| <= RAMP_STEP : cur <= tgt.
//   - diff >  RAMP_STEP   : cur <= cur + RAMP_STEP.
//   - diff < -RAMP_STEP   : cur <= cur - RAMP_STEP.
//   - cur is 11-bit signed; by construction it never leaves -1023..+1023.
//   - A sign reversal passes through the values between; it never jumps.
//   Outputs (registered, 1 cycle after cur updates)
//   - duty = clamp(11'h400 + cur, DUTY_MIN, DUTY_MAX).
//     Computed 12-bit before clamping, so no wrap.
//   - at_target = (cur_l==tgt_l) && (cur_r==tgt_r).
//   - Duty and at_target are therefore stable for a full period, and change
//     2 edges after the upd cycle begins.
//   - Between updates, all outputs except upd hold.
//   - Simultaneous en=0 and a nonzero spd: en wins, target is 0.
//
// STRUCTURE
//   - Package mtr_pkg holds:
//       typedef logic signed [10:0] spd_t;
//       localparam SPD_MAX = 1023;
//       localparam logic [10:0] DUTY_MID = 11'h400;
//   - The period counter and upd decode live in the top module.
//   - One sub-module, ramp_chan, is instantiated twice (left, right).
//     It contains sat, slew, cur register, duty clamp/register and an
//     eq flag. Its ports are clk, rst_n, upd, en, spd, duty, eq.
//   - at_target = eq_l & eq_r, registered in the top module.
//
// TESTING  (bench uses UPDATE_PERIOD=16, RAMP_STEP=8 unless noted)
//   1. Reset: hold rst_n=0 -> duties 0x400, upd=0, at_target=1.
//      Release -> first upd pulse 16 clks later, then every 16 clks.
//   2. Ramp up: en=1, lft_spd=+100 -> lft_duty steps 0x408,0x410,...,0x460
//      (12 updates), then 0x464 on the 13th. at_target=1 from that output.
//   3. Saturation: rght_spd=12'h7FF -> cur clips at +1023, duty holds 0x7F0.
//      rght_spd=12'h800 -> duty holds 0x010. No wrap at any point.
//   4. Reversal: cur_l=+40, lft_spd=-40 -> duties 0x420,0x418,...,0x3D8
//      over 10 updates, passing 0x400. Input changes mid-period are ignored.
//   5. Disable: cur_r=+200, en=0 -> rght_duty falls 8/update to 0x400 in 25
//      updates, even though rght_spd is still +200.
//   6. Async reset mid-ramp (cur=+64): rst_n low mid-period -> duties 0x400
//      immediately. Period restarts; ramp resumes from 0 after release.

Source files
------------

// File: rtl/mtr_pkg.sv
// Shared types and constants for the motor duty ramp: speed word type,
// speed saturation limit and the "stopped" duty code.
package mtr_pkg;

   typedef logic signed [10:0] spd_t;

   localparam int          SPD_MAX  = 1023;
   localparam logic [10:0] DUTY_MID = 11'h400;

   // Saturate a 12-bit signed command into the symmetric -1023..+1023 window.
   function automatic spd_t sat_spd(input logic signed [11:0] s);
      if (s > SPD_MAX)
         return spd_t'(SPD_MAX);
      else if (s < -SPD_MAX)
         return spd_t'(-SPD_MAX);
      else
         return s[10:0];
   endfunction

endpackage

// File: rtl/ramp_chan.sv
// One wheel channel: saturates the command, slews the internal speed once
// per update and converts it into a clamped, registered 11-bit duty word.
module ramp_chan
   import mtr_pkg::*;
#(
   parameter int          RAMP_STEP = 8,
   parameter logic [10:0] DUTY_MIN  = 11'h010,
   parameter logic [10:0] DUTY_MAX  = 11'h7F0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd,
   input  logic        en,
   input  logic [11:0] spd,
   output logic [10:0] duty,
   output logic        eq
);

   localparam logic signed [12:0] STEP = 13'(RAMP_STEP);

   spd_t               tgt;
   spd_t               tgt_q;
   spd_t               cur;
   spd_t               cur_nxt;
   logic signed [12:0] diff;
   logic signed [11:0] duty_sum;
   logic [10:0]        duty_nxt;

   always_comb begin
      tgt  = en ? sat_spd(signed'(spd)) : '0;
      diff = $signed({{2{tgt[10]}}, tgt}) - $signed({{2{cur[10]}}, cur});

      // Large errors move by exactly one step, so a sign reversal walks
      // through every intermediate value instead of jumping across zero.
      if (diff > STEP)
         cur_nxt = cur + spd_t'(RAMP_STEP);
      else if (diff < -STEP)
         cur_nxt = cur - spd_t'(RAMP_STEP);
      else
         cur_nxt = tgt;

      // 12-bit sum is always 1..2047, so clamping never sees a wrapped value.
      duty_sum = $signed({1'b0, DUTY_MID}) + $signed({cur[10], cur});
      if (duty_sum < $signed({1'b0, DUTY_MIN}))
         duty_nxt = DUTY_MIN;
      else if (duty_sum > $signed({1'b0, DUTY_MAX}))
         duty_nxt = DUTY_MAX;
      else
         duty_nxt = duty_sum[10:0];
   end

   // NOTE: state uses non-blocking assignments only; blocking ones here would
   // make the result depend on simulator event ordering between the two channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur   <= '0;
         tgt_q <= '0;
         duty  <= DUTY_MID;
      end else begin
         if (upd) begin
            cur   <= cur_nxt;
            tgt_q <= tgt;
         end
         duty <= duty_nxt;
      end
   end

   assign eq = (cur == tgt_q);

endmodule

// File: rtl/mtr_duty_ramp.sv
// Converts signed left/right speed commands into slew-limited, clamped
// 11-bit PWM duty words that change only once per PWM period.
module mtr_duty_ramp
   import mtr_pkg::*;
#(
   parameter int          RAMP_STEP     = 8,
   parameter int          UPDATE_PERIOD = 2048,
   parameter logic [10:0] DUTY_MIN      = 11'h010,
   parameter logic [10:0] DUTY_MAX      = 11'h7F0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] lft_spd,
   input  logic [11:0] rght_spd,
   output logic [10:0] lft_duty,
   output logic [10:0] rght_duty,
   output logic        upd,
   output logic        at_target
);

   localparam int               CNT_W = $clog2(UPDATE_PERIOD);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(UPDATE_PERIOD - 1);

   logic [CNT_W-1:0] cnt;
   logic             eq_l;
   logic             eq_r;

   // Free-running period counter; its last count lines up with the PWM wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         at_target <= 1'b1;
      end else begin
         cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
         at_target <= eq_l & eq_r;
      end
   end

   assign upd = (cnt == LAST);

   ramp_chan #(
      .RAMP_STEP (RAMP_STEP),
      .DUTY_MIN  (DUTY_MIN),
      .DUTY_MAX  (DUTY_MAX)
   ) u_lft (
      .clk   (clk),
      .rst_n (rst_n),
      .upd   (upd),
      .en    (en),
      .spd   (lft_spd),
      .duty  (lft_duty),
      .eq    (eq_l)
   );

   ramp_chan #(
      .RAMP_STEP (RAMP_STEP),
      .DUTY_MIN  (DUTY_MIN),
      .DUTY_MAX  (DUTY_MAX)
   ) u_rght (
      .clk   (clk),
      .rst_n (rst_n),
      .upd   (upd),
      .en    (en),
      .spd   (rght_spd),
      .duty  (rght_duty),
      .eq    (eq_r)
   );

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Self-checking bench for mtr_duty_ramp: constant vector tables for the
// ramp, reversal and disable cases plus random updates against a speed model.
module tb_mtr_duty_ramp;

   localparam int PERIOD = 16;
   localparam int STEP   = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [11:0] lft_spd;
   logic [11:0] rght_spd;
   logic [10:0] lft_duty;
   logic [10:0] rght_duty;
   logic        upd;
   logic        at_target;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: wheel speeds and the targets of the last update.
   int ml = 0, mr = 0, tl = 0, tr = 0;

   typedef struct {
      logic        en;
      logic [11:0] l;
      logic [11:0] r;
      logic [10:0] el;
      logic [10:0] er;
      logic        eat;
   } vec_t;

   vec_t ramp_tab[13];
   vec_t rev_tab[10];
   vec_t dis_tab[25];

   mtr_duty_ramp #(
      .RAMP_STEP     (STEP),
      .UPDATE_PERIOD (PERIOD),
      .DUTY_MIN      (11'h010),
      .DUTY_MAX      (11'h7F0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .lft_spd   (lft_spd),
      .rght_spd  (rght_spd),
      .lft_duty  (lft_duty),
      .rght_duty (rght_duty),
      .upd       (upd),
      .at_target (at_target)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int m_sat(input int s);
      if (s > 1023) return 1023;
      if (s < -1023) return -1023;
      return s;
   endfunction

   function automatic int m_slew(input int c, input int t);
      if (t - c > STEP) return c + STEP;
      if (t - c < -STEP) return c - STEP;
      return t;
   endfunction

   function automatic int m_duty(input int c);
      int d = 1024 + c;
      if (d < 16) return 16;
      if (d > 2032) return 2032;
      return d;
   endfunction

   // One update: drive inputs in the upd cycle, scramble them mid-period,
   // then compare outputs once they have settled.
   task automatic step(input logic e, input logic [11:0] l, input logic [11:0] r);
      int n = 0;
      while (upd !== 1'b1 && n < 4 * PERIOD) begin
         @(negedge clk);
         n++;
      end
      if (upd !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL upd_timeout: no upd within %0d cycles", 4 * PERIOD);
         return;
      end
      en       = e;
      lft_spd  = l;
      rght_spd = r;
      tl = e ? m_sat(int'($signed(l))) : 0;
      tr = e ? m_sat(int'($signed(r))) : 0;
      ml = m_slew(ml, tl);
      mr = m_slew(mr, tr);
      @(posedge clk);
      @(negedge clk);
      en       = 1'($urandom);
      lft_spd  = 12'($urandom);
      rght_spd = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("model_lft_duty", int'(lft_duty), m_duty(ml));
      check("model_rght_duty", int'(rght_duty), m_duty(mr));
      check("model_at_target", int'(at_target), int'(ml == tl && mr == tr));
      check("upd_low_after", int'(upd), 0);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      step(v.en, v.l, v.r);
      check({tag, "_lft_duty"}, int'(lft_duty), int'(v.el));
      check({tag, "_rght_duty"}, int'(rght_duty), int'(v.er));
      check({tag, "_at_target"}, int'(at_target), int'(v.eat));
   endtask

   // Release reset and check the first pulse lands in the 16th cycle after
   // release (15 rising edges), and the next one a full period later.
   task automatic release_and_time();
      int n = 0;
      @(negedge clk);
      rst_n = 1'b1;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (upd !== 1'b1 && n < 4 * PERIOD);
      check("first_upd_edges", n, PERIOD - 1);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (upd !== 1'b1 && n < 4 * PERIOD);
      check("upd_period", n, PERIOD);
   endtask

   initial begin
      for (int i = 0; i < 13; i++)
         ramp_tab[i] = '{1'b1, 12'd100, 12'd0,
                         (i < 12) ? 11'(11'h400 + 8 * (i + 1)) : 11'h464,
                         11'h400, (i == 12)};
      for (int i = 0; i < 10; i++)
         rev_tab[i] = '{1'b1, 12'hFD8, 12'd0, 11'(11'h420 - 8 * i),
                        11'h400, (i == 9)};
      for (int i = 0; i < 25; i++)
         dis_tab[i] = '{1'b0, 12'hFD8, 12'd200,
                        (i < 4) ? 11'(11'h3D8 + 8 * (i + 1)) : 11'h400,
                        11'(11'h400 + 200 - 8 * (i + 1)), (i == 24)};

      rst_n    = 1'b0;
      en       = 1'b0;
      lft_spd  = '0;
      rght_spd = '0;
      #23;
      check("rst_lft_duty", int'(lft_duty), 'h400);
      check("rst_rght_duty", int'(rght_duty), 'h400);
      check("rst_upd", int'(upd), 0);
      check("rst_at_target", int'(at_target), 1);
      release_and_time();

      foreach (ramp_tab[i]) run_vec("ramp", ramp_tab[i]);

      repeat (130) step(1'b1, 12'd100, 12'h7FF);
      check("sat_pos_rght_duty", int'(rght_duty), 'h7F0);
      repeat (260) step(1'b1, 12'd100, 12'h800);
      check("sat_neg_rght_duty", int'(rght_duty), 'h010);

      repeat (130) step(1'b1, 12'd40, 12'd0);
      check("pre_rev_lft_duty", int'(lft_duty), 'h428);
      foreach (rev_tab[i]) run_vec("rev", rev_tab[i]);

      repeat (25) step(1'b1, 12'hFD8, 12'd200);
      check("pre_dis_rght_duty", int'(rght_duty), 'h4C8);
      foreach (dis_tab[i]) run_vec("dis", dis_tab[i]);

      repeat (60) step(1'($urandom), 12'($urandom), 12'($urandom));

      rst_n = 1'b0;
      #7;
      ml = 0; mr = 0; tl = 0; tr = 0;
      release_and_time();
      repeat (8) step(1'b1, 12'd200, 12'd200);
      check("mid_lft_duty", int'(lft_duty), 'h440);
      check("mid_at_target", int'(at_target), 0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_lft_duty", int'(lft_duty), 'h400);
      check("async_rght_duty", int'(rght_duty), 'h400);
      check("async_at_target", int'(at_target), 1);
      check("async_upd", int'(upd), 0);
      ml = 0; mr = 0; tl = 0; tr = 0;
      release_and_time();
      step(1'b1, 12'd200, 12'd200);
      check("resume_rght_duty", int'(rght_duty), 'h408);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
